// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// One multiplier bit per cycle, fixed DATAWIDTH-cycle run.
module seq_multiplier #(
   parameter int DATAWIDTH = 32
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     start,
   input  logic [DATAWIDTH-1:0]     a,
   input  logic [DATAWIDTH-1:0]     b,
   output logic [2*DATAWIDTH-1:0]   product,
   output logic                     busy,
   output logic                     done
);

   localparam int PW = 2 * DATAWIDTH;
   localparam int CW = $clog2(DATAWIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_n;
   logic [PW-1:0]   mcand;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   acc_next;
   logic [DATAWIDTH-1:0] mplier;
   logic [CW-1:0]   count;
   logic            last_iter;

   // partial-product add for the current multiplier bit
   always_comb begin
      acc_next  = acc + (mplier[0] ? mcand : '0);
      last_iter = (count == LAST);
   end

   // state register
   always_ff @(posedge Clk) begin
      if (Rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // next-state and status outputs
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start)
               state_n = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_iter)
               state_n = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // datapath: operand capture, shift-add iterations, result load
   always_ff @(posedge Clk) begin
      if (Rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         product <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  mcand  <= PW'(a);
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
               end
            end
            S_RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
               if (last_iter)
                  product <= acc_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: DATAWIDTH, 32, operand width in bits; product width is 2*DATAWIDTH.
REQ-002 Port: Clk  input  1  rising-edge clock for all state.
REQ-003 Port: Rst  input  1  synchronous, active-high reset; sampled on rising Clk only.
REQ-004 Port: start  input  1  request to begin a multiply; accepted only in IDLE.
REQ-005 Port: a  input  DATAWIDTH  unsigned multiplicand; sampled on the accepting edge.
REQ-006 Port: b  input  DATAWIDTH  unsigned multiplier; sampled on the accepting edge.
REQ-007 Port: product  output  2*DATAWIDTH  registered result of the last completed multiply.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle completion pulse, concurrent with a new product value.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE with start=1 at a rising edge SHALL: latch mcand = a zero-extended to 2*DATAWIDTH, mplier = b, acc = 0, count = 0, and go to RUN.
REQ-012 IDLE with start=0 SHALL hold all registers.
REQ-013 Each RUN cycle SHALL: if mplier[0]=1 then acc = acc + mcand (2*DATAWIDTH-bit, no overflow possible); mcand shifts left 1 (zero fill); mplier shifts right 1 (zero fill); count increments.
REQ-014 RUN SHALL last exactly DATAWIDTH cycles regardless of operand values (no early termination).
REQ-015 On the edge completing the DATAWIDTH-th RUN iteration, the FSM SHALL go to DONE and product SHALL load the final acc value in that same edge.
REQ-016 DONE SHALL last exactly one cycle, then unconditionally return to IDLE.
REQ-017 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-018 Latency: if start is accepted at edge k, busy SHALL be high for cycles k+1..k+DATAWIDTH and done SHALL be high in the cycle following edge k+DATAWIDTH.
REQ-019 start asserted in RUN or DONE SHALL be ignored; it is not queued, and the in-flight operation SHALL be unaffected.
REQ-020 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-021 product SHALL change only on entry to DONE and on reset, and SHALL otherwise hold its value across IDLE and RUN.
REQ-022 Arithmetic SHALL be unsigned; product = a*b exactly for all inputs, including the all-ones operands.
REQ-023 A start held high continuously SHALL cause back-to-back operations: one IDLE cycle between DONE and the next RUN.

Reset
REQ-024 Rst=1 at a rising edge SHALL force state=IDLE, product=0, busy=0, done=0, acc=0, mcand=0, mplier=0, count=0; this has priority over start.
REQ-025 Rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse, and product SHALL read 0.
REQ-026 On the first edge with Rst=0, a start=1 SHALL be accepted normally.

Verification
REQ-027 a=1, b=2, start pulsed 1 cycle -> busy high 32 cycles, then done pulse with product=0x0000000000000002.
REQ-028 a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 on the done cycle; a and b changed to 0 one cycle after start -> result unchanged.
REQ-029 a=0x40000000, b=4 -> product=0x0000000100000000; then a=0, b=0x12345678 -> product=0 after the second done.
REQ-030 a=3, b=5 accepted; start re-pulsed at RUN cycle 10 with a=7, b=7 -> exactly one done pulse, product=15, then FSM in IDLE.
REQ-031 a=3, b=5 accepted, Rst=1 at RUN cycle 16 -> next cycle busy=0, done=0, product=0; no done pulse within the following 40 cycles unless start is asserted.
REQ-032 start held at 1 with a=2, b=3 -> done pulses every 34 cycles with product=6.
